// File: rtl/ascon_block_driver.sv
// Host-side block driver for the ASCON-128 core: starts the core, hands it one AD block and
// N_BLK text blocks over a valid/accept handshake, forwards output blocks and the tag.
module ascon_block_driver #(
    parameter int unsigned N_BLK   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         decrypt_i,
    input  logic         host_valid_i,
    input  logic [63:0]  host_data_i,
    output logic         host_ready_o,
    output logic         core_start_o,
    output logic         core_decrypt_o,
    output logic         core_data_valid_o,
    output logic [63:0]  core_data_o,
    input  logic         core_accept_i,
    input  logic         core_cipher_we_i,
    input  logic [63:0]  core_cipher_i,
    input  logic         core_tag_we_i,
    input  logic [127:0] core_tag_i,
    input  logic         core_end_i,
    output logic         out_valid_o,
    output logic [63:0]  out_data_o,
    output logic [127:0] tag_o,
    output logic         done_o,
    output logic         err_o,
    output logic         busy_o
);

    localparam int unsigned CntW = $clog2(N_BLK + 2);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StFetch,
        StOffer,
        StWaitEnd,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [CntW-1:0] blk_cnt_q, blk_cnt_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic           decrypt_q, decrypt_d;
    logic [63:0]    data_q, data_d;
    logic           err_q, err_d;
    logic [127:0]   tag_q, tag_d;
    logic           out_valid_q;
    logic [63:0]    out_data_q;
    logic           tmo_hit;

    assign tmo_hit = (tmo_q == TmoW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        blk_cnt_d = blk_cnt_q;
        tmo_d     = tmo_q;
        decrypt_d = decrypt_q;
        data_d    = data_q;
        err_d     = err_q;
        tag_d     = tag_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d   = StStart;
                    decrypt_d = decrypt_i;
                    err_d     = 1'b0;
                    tag_d     = '0;
                    blk_cnt_d = '0;
                end
            end
            StStart: state_d = StFetch;
            StFetch: begin
                if (host_valid_i) begin
                    data_d  = host_data_i;
                    tmo_d   = '0;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                // Accept takes priority over an expiring timeout in the same cycle.
                if (core_accept_i) begin
                    blk_cnt_d = blk_cnt_q + 1'b1;
                    tmo_d     = '0;
                    state_d   = (blk_cnt_q == CntW'(N_BLK)) ? StWaitEnd : StFetch;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWaitEnd: begin
                if (core_end_i) begin
                    state_d = StDone;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // The core may deliver the tag in any state, including alongside core_end_i.
        if (core_tag_we_i) begin
            tag_d = core_tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            blk_cnt_q   <= '0;
            tmo_q       <= '0;
            decrypt_q   <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            blk_cnt_q   <= blk_cnt_d;
            tmo_q       <= tmo_d;
            decrypt_q   <= decrypt_d;
            data_q      <= data_d;
            err_q       <= err_d;
            tag_q       <= tag_d;
            out_valid_q <= core_cipher_we_i;
            if (core_cipher_we_i) begin
                out_data_q <= core_cipher_i;
            end
        end
    end

    assign host_ready_o      = (state_q == StFetch);
    assign core_start_o      = (state_q == StStart);
    assign core_data_valid_o = (state_q == StOffer);
    assign done_o            = (state_q == StDone);
    assign busy_o            = (state_q != StIdle);
    assign core_decrypt_o    = decrypt_q;
    assign core_data_o       = data_q;
    assign err_o             = err_q;
    assign tag_o             = tag_q;
    assign out_valid_o       = out_valid_q;
    assign out_data_o        = out_data_q;

endmodule

// File: tb/tb_ascon_block_driver.sv
// Directed bench for ascon_block_driver: full messages, host stall, mid-message start,
// core timeout, and reset in the middle of a message.
module tb_ascon_block_driver;

    localparam int N_BLK = 4;
    localparam int TMO   = 64;
    localparam logic [63:0] MASK = 64'hA5A5_5A5A_F00F_0FF0;

    logic         clk = 1'b0;
    logic         rst_i, start_i, decrypt_i, host_valid_i;
    logic [63:0]  host_data_i;
    logic         host_ready_o, core_start_o, core_decrypt_o, core_data_valid_o;
    logic [63:0]  core_data_o;
    logic         core_accept_i, core_cipher_we_i, core_tag_we_i, core_end_i;
    logic [63:0]  core_cipher_i;
    logic [127:0] core_tag_i;
    logic         out_valid_o, done_o, err_o, busy_o;
    logic [63:0]  out_data_o;
    logic [127:0] tag_o;

    int checks = 0;
    int errors = 0;

    int n_start = 0, n_done = 0, n_acc = 0, n_out = 0;
    logic [63:0] acc_log [64];
    logic [63:0] out_log [64];

    always #5 clk = ~clk;

    ascon_block_driver #(.N_BLK(N_BLK), .TIMEOUT(TMO)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .decrypt_i         (decrypt_i),
        .host_valid_i      (host_valid_i),
        .host_data_i       (host_data_i),
        .host_ready_o      (host_ready_o),
        .core_start_o      (core_start_o),
        .core_decrypt_o    (core_decrypt_o),
        .core_data_valid_o (core_data_valid_o),
        .core_data_o       (core_data_o),
        .core_accept_i     (core_accept_i),
        .core_cipher_we_i  (core_cipher_we_i),
        .core_cipher_i     (core_cipher_i),
        .core_tag_we_i     (core_tag_we_i),
        .core_tag_i        (core_tag_i),
        .core_end_i        (core_end_i),
        .out_valid_o       (out_valid_o),
        .out_data_o        (out_data_o),
        .tag_o             (tag_o),
        .done_o            (done_o),
        .err_o             (err_o),
        .busy_o            (busy_o)
    );

    // Event recorder: pulse counts plus the order of accepted and forwarded blocks.
    always @(posedge clk) begin
        if (core_start_o) n_start <= n_start + 1;
        if (done_o) n_done <= n_done + 1;
        if (core_accept_i && core_data_valid_o) begin
            acc_log[n_acc % 64] <= core_data_o;
            n_acc <= n_acc + 1;
        end
        if (out_valid_o) begin
            out_log[n_out % 64] <= out_data_o;
            n_out <= n_out + 1;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {busy_o, host_ready_o, core_start_o, core_decrypt_o,
                              core_data_valid_o, out_valid_o, done_o, err_o}, 8'h00);
        check({tag, "_core_data"}, core_data_o, 64'h0);
        check({tag, "_out_data"}, out_data_o, 64'h0);
        check({tag, "_tag"}, tag_o, 128'h0);
    endtask

    task automatic start_msg(input logic dec);
        start_i = 1'b1;
        decrypt_i = dec;
        @(negedge clk);
        start_i = 1'b0;
        decrypt_i = ~dec;
        check("start_pulse", core_start_o, 1'b1);
        check("start_busy", busy_o, 1'b1);
        check("start_err_clear", err_o, 1'b0);
        @(negedge clk);
        check("start_one_cycle", core_start_o, 1'b0);
    endtask

    task automatic host_block(input logic [63:0] d, input int stall);
        for (int i = 0; i < stall; i++) begin
            check("stall_ready", host_ready_o, 1'b1);
            check("stall_valid", core_data_valid_o, 1'b0);
            @(negedge clk);
        end
        check("fetch_ready", host_ready_o, 1'b1);
        host_valid_i = 1'b1;
        host_data_i = d;
        @(negedge clk);
        host_valid_i = 1'b0;
        host_data_i = ~d;
        check("offer_valid", core_data_valid_o, 1'b1);
        check("offer_data", core_data_o, d);
    endtask

    task automatic core_accept(input logic [63:0] d, input int delay, input logic cipher);
        for (int i = 0; i < delay; i++) begin
            check("hold_valid", core_data_valid_o, 1'b1);
            check("hold_data", core_data_o, d);
            @(negedge clk);
        end
        core_accept_i = 1'b1;
        core_cipher_we_i = cipher;
        core_cipher_i = d ^ MASK;
        @(negedge clk);
        core_accept_i = 1'b0;
        core_cipher_we_i = 1'b0;
        check("accept_drop", core_data_valid_o, 1'b0);
        if (cipher) begin
            check("fwd_valid", out_valid_o, 1'b1);
            check("fwd_data", out_data_o, d ^ MASK);
        end
    endtask

    task automatic run_msg(input logic dec, input logic [63:0] base, input int stall_idx,
                           input int stall_n, input logic [127:0] tag, input logic disturb);
        int s0, d0, a0, o0;
        logic [63:0] d;
        s0 = n_start; d0 = n_done; a0 = n_acc; o0 = n_out;
        start_msg(dec);
        for (int b = 0; b <= N_BLK; b++) begin
            d = base + 64'(b);
            host_block(d, (b == stall_idx) ? stall_n : 0);
            if (disturb && b == 1) begin
                start_i = 1'b1;
                host_valid_i = 1'b1;
                host_data_i = 64'hDEAD_BEEF_DEAD_BEEF;
                @(negedge clk);
                start_i = 1'b0;
                host_valid_i = 1'b0;
                check("ign_start", core_start_o, 1'b0);
                check("ign_host_data", core_data_o, d);
            end
            core_accept(d, 3, b > 0);
        end
        check("wait_end_busy", busy_o, 1'b1);
        check("wait_end_ready", host_ready_o, 1'b0);
        core_tag_we_i = 1'b1;
        core_tag_i = tag;
        core_end_i = 1'b1;
        @(negedge clk);
        core_tag_we_i = 1'b0;
        core_end_i = 1'b0;
        check("done_pulse", done_o, 1'b1);
        check("tag_before_done", tag_o, tag);
        check("done_err", err_o, 1'b0);
        check("decrypt_latched", core_decrypt_o, dec);
        @(negedge clk);
        check("done_one_cycle", done_o, 1'b0);
        check("idle_busy", busy_o, 1'b0);
        check("tag_held", tag_o, tag);
        check("n_start", n_start - s0, 1);
        check("n_done", n_done - d0, 1);
        check("n_accept", n_acc - a0, N_BLK + 1);
        check("n_out", n_out - o0, N_BLK);
        for (int i = 0; i <= N_BLK; i++)
            check("accept_order", acc_log[(a0 + i) % 64], base + 64'(i));
        for (int i = 0; i < N_BLK; i++)
            check("out_order", out_log[(o0 + i) % 64], (base + 64'(i + 1)) ^ MASK);
    endtask

    initial begin
        int d0;
        rst_i = 1'b1; start_i = 1'b0; decrypt_i = 1'b0; host_valid_i = 1'b0;
        host_data_i = '0; core_accept_i = 1'b0; core_cipher_we_i = 1'b0;
        core_cipher_i = '0; core_tag_we_i = 1'b0; core_tag_i = '0; core_end_i = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_i = 1'b0;
        @(negedge clk);

        // Stray accept while idle does nothing.
        core_accept_i = 1'b1;
        @(negedge clk);
        core_accept_i = 1'b0;
        check("idle_accept_busy", busy_o, 1'b0);

        run_msg(1'b0, 64'h1111_2222_3333_0000, -1, 0, 128'hC0FFEE00_11223344_55667788_99AABBCC,
                1'b0);
        run_msg(1'b1, 64'h4444_5555_6666_0100, 2, 10, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                1'b1);

        // Core never accepts text block 1.
        d0 = n_done;
        start_msg(1'b0);
        host_block(64'h7000_0000_0000_0000, 0);
        core_accept(64'h7000_0000_0000_0000, 1, 1'b0);
        host_block(64'h7000_0000_0000_0001, 0);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_not_yet_err", err_o, 1'b0);
        check("tmo_not_yet_valid", core_data_valid_o, 1'b1);
        @(negedge clk);
        check("tmo_err", err_o, 1'b1);
        check("tmo_busy", busy_o, 1'b0);
        check("tmo_valid", core_data_valid_o, 1'b0);
        @(negedge clk);
        check("tmo_err_sticky", err_o, 1'b1);
        check("tmo_no_done", n_done - d0, 0);

        // Next start clears err_o; reset lands while a block is on offer.
        start_msg(1'b1);
        host_block(64'h8000_0000_0000_0000, 0);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check_zero("mid_reset");

        run_msg(1'b0, 64'h9999_0000_0000_0200, -1, 0, 128'h5555_AAAA_5555_AAAA_0F0F_F0F0_1234_5678,
                1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
